doc5503_wave_responder: RTL and testbench

- Responder end of the DOC5503 wave-memory read interface (wave_address/wave_rd → wave_data/wave_data_ready).
- Serves oscillator sample fetches from a 64 KB sound RAM behind a generic ack-based memory port.
- Also accepts sound-GLU host writes into the same RAM.
- Arbitrates between the two, forwards pending write data to reads, holds a one-entry read cache, and guarantees a bounded reply via timeout.

---
 rtl/doc5503_pkg.sv | 16 +
 rtl/doc5503_wave_responder.sv | 206 ++++++++++++++++++++
 tb/tb_doc5503_wave_responder.sv | 286 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/doc5503_pkg.sv
// Shared types and constants for the DOC5503 wave-memory responder.
package doc5503_pkg;

    localparam int WAVE_ADDR_W = 16;
    localparam int WAVE_DATA_W = 8;

    // Sample value the DOC interprets as "halt oscillator"; replies must avoid it when synthesised.
    localparam logic [WAVE_DATA_W-1:0] DOC_HALT_BYTE = 8'h00;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RD_MEM = 2'd1,
        WR_MEM = 2'd2
    } state_e;

endpackage

// File: rtl/doc5503_wave_responder.sv
// DOC5503 wave-read responder: arbitrates DOC sample fetches and host writes onto one
// ack-based RAM port, with write forwarding, a one-entry read cache and an access timeout.
module doc5503_wave_responder
    import doc5503_pkg::*;
#(
    parameter int                       TIMEOUT_CYCLES = 32,
    parameter logic [WAVE_DATA_W-1:0]   TIMEOUT_DATA   = 8'h80
) (
    input  logic                    clk_i,
    input  logic                    reset_n_i,
    input  logic [WAVE_ADDR_W-1:0]  wave_address_i,
    input  logic                    wave_rd_i,
    output logic [WAVE_DATA_W-1:0]  wave_data_o,
    output logic                    wave_data_ready_o,
    input  logic                    host_we_i,
    input  logic [WAVE_ADDR_W-1:0]  host_addr_i,
    input  logic [WAVE_DATA_W-1:0]  host_data_i,
    output logic                    host_busy_o,
    output logic [WAVE_ADDR_W-1:0]  mem_addr_o,
    output logic                    mem_rd_o,
    output logic                    mem_wr_o,
    output logic [WAVE_DATA_W-1:0]  mem_wdata_o,
    input  logic [WAVE_DATA_W-1:0]  mem_rdata_i,
    input  logic                    mem_ack_i,
    output logic                    overrun_o
);

    localparam int              CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e                     state_q, state_d;
    logic [CNT_W-1:0]           tmo_cnt_q, tmo_cnt_d;
    logic                       rd_pend_q, rd_pend_d;
    logic [WAVE_ADDR_W-1:0]     rd_addr_q, rd_addr_d;
    logic                       host_busy_q, host_busy_d;
    logic [WAVE_ADDR_W-1:0]     wr_addr_q, wr_addr_d;
    logic [WAVE_DATA_W-1:0]     wr_data_q, wr_data_d;
    logic                       cache_vld_q, cache_vld_d;
    logic [WAVE_ADDR_W-1:0]     cache_addr_q, cache_addr_d;
    logic [WAVE_DATA_W-1:0]     cache_data_q, cache_data_d;
    logic [WAVE_DATA_W-1:0]     wave_data_q, wave_data_d;
    logic                       ready_q, ready_d;
    logic [WAVE_ADDR_W-1:0]     mem_addr_q, mem_addr_d;
    logic                       mem_rd_q, mem_rd_d;
    logic                       mem_wr_q, mem_wr_d;
    logic [WAVE_DATA_W-1:0]     mem_wdata_q, mem_wdata_d;
    logic                       overrun_q, overrun_d;

    logic wr_accept;
    logic rd_block;
    logic tmo_hit;

    assign wr_accept = host_we_i && !host_busy_q;
    assign rd_block  = rd_pend_q || (state_q == RD_MEM);
    assign tmo_hit   = (tmo_cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        tmo_cnt_d    = (state_q == IDLE) ? '0 : tmo_cnt_q + CNT_W'(1);
        rd_pend_d    = rd_pend_q;
        rd_addr_d    = rd_addr_q;
        host_busy_d  = host_busy_q;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        cache_vld_d  = cache_vld_q;
        cache_addr_d = cache_addr_q;
        cache_data_d = cache_data_q;
        wave_data_d  = wave_data_q;
        ready_d      = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_rd_d     = mem_rd_q;
        mem_wr_d     = mem_wr_q;
        mem_wdata_d  = mem_wdata_q;
        overrun_d    = overrun_q;

        if (wr_accept) begin
            host_busy_d = 1'b1;
            wr_addr_d   = host_addr_i;
            wr_data_d   = host_data_i;
        end
        if (host_we_i && host_busy_q) begin
            overrun_d = 1'b1;
        end

        // Forward/hit are resolved on the request itself so the reply lands one cycle later;
        // a same-cycle host write counts as already latched.
        if (wave_rd_i) begin
            if (rd_block) begin
                overrun_d = 1'b1;
            end else if (wr_accept && (host_addr_i == wave_address_i)) begin
                wave_data_d = host_data_i;
                ready_d     = 1'b1;
            end else if (host_busy_q && (wr_addr_q == wave_address_i)) begin
                wave_data_d = wr_data_q;
                ready_d     = 1'b1;
            end else if (cache_vld_q && (cache_addr_q == wave_address_i)) begin
                wave_data_d = cache_data_q;
                ready_d     = 1'b1;
            end else begin
                rd_pend_d = 1'b1;
                rd_addr_d = wave_address_i;
            end
        end

        case (state_q)
            IDLE: begin
                if (rd_pend_q) begin
                    state_d    = RD_MEM;
                    rd_pend_d  = 1'b0;
                    mem_rd_d   = 1'b1;
                    mem_addr_d = rd_addr_q;
                end else if (host_busy_q) begin
                    state_d     = WR_MEM;
                    mem_wr_d    = 1'b1;
                    mem_addr_d  = wr_addr_q;
                    mem_wdata_d = wr_data_q;
                end
            end
            RD_MEM: begin
                if (mem_ack_i) begin
                    state_d      = IDLE;
                    mem_rd_d     = 1'b0;
                    wave_data_d  = mem_rdata_i;
                    ready_d      = 1'b1;
                    cache_vld_d  = 1'b1;
                    cache_addr_d = mem_addr_q;
                    cache_data_d = mem_rdata_i;
                end else if (tmo_hit) begin
                    state_d     = IDLE;
                    mem_rd_d    = 1'b0;
                    wave_data_d = TIMEOUT_DATA;
                    ready_d     = 1'b1;
                end
            end
            WR_MEM: begin
                if (mem_ack_i) begin
                    state_d     = IDLE;
                    mem_wr_d    = 1'b0;
                    host_busy_d = 1'b0;
                    if (cache_vld_q && (cache_addr_q == mem_addr_q)) begin
                        cache_data_d = mem_wdata_q;
                    end
                end else if (tmo_hit) begin
                    state_d     = IDLE;
                    mem_wr_d    = 1'b0;
                    host_busy_d = 1'b0;
                end
            end
            default: begin
                state_d  = IDLE;
                mem_rd_d = 1'b0;
                mem_wr_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q      <= IDLE;
            tmo_cnt_q    <= '0;
            rd_pend_q    <= 1'b0;
            rd_addr_q    <= '0;
            host_busy_q  <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            cache_vld_q  <= 1'b0;
            cache_addr_q <= '0;
            cache_data_q <= '0;
            wave_data_q  <= '0;
            ready_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_wdata_q  <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmo_cnt_q    <= tmo_cnt_d;
            rd_pend_q    <= rd_pend_d;
            rd_addr_q    <= rd_addr_d;
            host_busy_q  <= host_busy_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            cache_vld_q  <= cache_vld_d;
            cache_addr_q <= cache_addr_d;
            cache_data_q <= cache_data_d;
            wave_data_q  <= wave_data_d;
            ready_q      <= ready_d;
            mem_addr_q   <= mem_addr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_wdata_q  <= mem_wdata_d;
            overrun_q    <= overrun_d;
        end
    end

    assign wave_data_o       = wave_data_q;
    assign wave_data_ready_o = ready_q;
    assign host_busy_o       = host_busy_q;
    assign mem_addr_o        = mem_addr_q;
    assign mem_rd_o          = mem_rd_q;
    assign mem_wr_o          = mem_wr_q;
    assign mem_wdata_o       = mem_wdata_q;
    assign overrun_o         = overrun_q;

endmodule

// File: tb/tb_doc5503_wave_responder.sv
// Bench for doc5503_wave_responder: directed scenarios plus a randomized phase checked
// against an architectural memory image and a reply scoreboard.
module tb_doc5503_wave_responder;

    logic        clk_i = 1'b0;
    logic        reset_n_i = 1'b0;
    logic [15:0] wave_address_i = '0;
    logic        wave_rd_i = 1'b0;
    logic [7:0]  wave_data_o;
    logic        wave_data_ready_o;
    logic        host_we_i = 1'b0;
    logic [15:0] host_addr_i = '0;
    logic [7:0]  host_data_i = '0;
    logic        host_busy_o;
    logic [15:0] mem_addr_o;
    logic        mem_rd_o;
    logic        mem_wr_o;
    logic [7:0]  mem_wdata_o;
    logic [7:0]  mem_rdata_i = '0;
    logic        mem_ack_i = 1'b0;
    logic        overrun_o;

    doc5503_wave_responder #(.TIMEOUT_CYCLES(32), .TIMEOUT_DATA(8'h80)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i),
        .wave_address_i(wave_address_i), .wave_rd_i(wave_rd_i),
        .wave_data_o(wave_data_o), .wave_data_ready_o(wave_data_ready_o),
        .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_data_i(host_data_i),
        .host_busy_o(host_busy_o),
        .mem_addr_o(mem_addr_o), .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    logic [7:0] mem [0:65535];
    logic [7:0] shadow [0:7];
    logic [7:0] exp_q [$];
    int  n_chk = 0, n_pass = 0;
    int  ack_delay = 0;          // -1: never ack, -2: random 0..4
    int  mcnt = -1;
    bit  mreq_act = 0, busy_m = 0, wr_ack_prev = 0;
    bit  s_ready, s_mem_rd, s_mem_wr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // One clock: sample outputs at negedge, run the memory model, drop pulse inputs.
    task automatic tick();
        @(negedge clk_i);
        if (host_we_i && !busy_m) busy_m = 1;
        if (wr_ack_prev) busy_m = 0;
        wr_ack_prev = 0;
        wave_rd_i = 0;
        host_we_i = 0;
        mem_ack_i = 0;
        mem_rdata_i = 8'($urandom);
        s_ready = wave_data_ready_o;
        s_mem_rd = mem_rd_o;
        s_mem_wr = mem_wr_o;
        chk("host_busy", 32'(host_busy_o), 32'(busy_m));
        chk("rd_wr_excl", 32'(mem_rd_o & mem_wr_o), 0);
        if (wave_data_ready_o) begin
            if (exp_q.size() == 0) chk("spurious_reply", 1, 0);
            else chk("reply_data", 32'(wave_data_o), 32'(exp_q.pop_front()));
        end
        if (mem_rd_o || mem_wr_o) begin
            if (!mreq_act) begin
                mreq_act = 1;
                mcnt = (ack_delay == -2) ? int'($urandom_range(0, 4)) : ack_delay;
            end
            if (mcnt == 0) begin
                mem_ack_i = 1;
                mreq_act = 0;
                mcnt = -1;
                if (mem_rd_o) mem_rdata_i = mem[mem_addr_o];
                else begin
                    mem[mem_addr_o] = mem_wdata_o;
                    wr_ack_prev = 1;
                end
            end else if (mcnt > 0) mcnt--;
        end else mreq_act = 0;
    endtask

    task automatic issue_rd(input logic [15:0] a, input logic [7:0] e);
        wave_rd_i = 1;
        wave_address_i = a;
        exp_q.push_back(e);
    endtask

    task automatic issue_wr(input logic [15:0] a, input logic [7:0] d);
        host_we_i = 1;
        host_addr_i = a;
        host_data_i = d;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while ((exp_q.size() != 0 || busy_m) && n < 100) begin
            tick();
            n++;
        end
        chk(tag, 32'(exp_q.size() != 0 || busy_m), 0);
    endtask

    task automatic do_reset();
        reset_n_i = 0;
        wave_rd_i = 0; host_we_i = 0; mem_ack_i = 0;
        busy_m = 0; wr_ack_prev = 0; mreq_act = 0; mcnt = -1;
        exp_q.delete();
        repeat (2) @(negedge clk_i);
        chk("rst_wave_data", 32'(wave_data_o), 0);
        chk("rst_ready", 32'(wave_data_ready_o), 0);
        chk("rst_busy", 32'(host_busy_o), 0);
        chk("rst_mem_addr", 32'(mem_addr_o), 0);
        chk("rst_mem_rdwr", 32'({mem_rd_o, mem_wr_o}), 0);
        chk("rst_mem_wdata", 32'(mem_wdata_o), 0);
        chk("rst_overrun", 32'(overrun_o), 0);
        reset_n_i = 1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int hi_cnt;
        bit got_wr;
        logic [15:0] a;
        logic [7:0] d;
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h1234] = 8'h5A;
        mem[16'h0100] = 8'h11;
        mem[16'h2000] = 8'h3C;
        mem[16'h4444] = 8'h29;

        // Cold read, then cache hit
        do_reset();
        ack_delay = 3;
        issue_rd(16'h1234, 8'h5A);
        tick();
        chk("cold_no_early_rd", 32'(s_mem_rd), 0);
        chk("cold_no_early_rdy", 32'(s_ready), 0);
        tick();
        chk("cold_rd_lat2", 32'(s_mem_rd), 1);
        chk("cold_addr", 32'(mem_addr_o), 32'h1234);
        wait_idle("cold_done");
        issue_rd(16'h1234, 8'h5A);
        tick();
        chk("hit_lat1", 32'(s_ready), 1);
        chk("hit_no_mem", 32'(s_mem_rd), 0);
        tick();
        chk("hit_no_mem2", 32'(s_mem_rd), 0);

        // Forwarding from a stalled write
        do_reset();
        ack_delay = 6;
        issue_wr(16'h0100, 8'hC3);
        tick();
        tick();
        chk("fwd_wr_started", 32'(s_mem_wr), 1);
        issue_rd(16'h0100, 8'hC3);
        tick();
        chk("fwd_lat1", 32'(s_ready), 1);
        chk("fwd_mem_pending", 32'(mem[16'h0100]), 32'h11);
        wait_idle("fwd_done");
        chk("fwd_mem_written", 32'(mem[16'h0100]), 32'hC3);

        // Pending read beats pending write
        do_reset();
        ack_delay = 2;
        issue_wr(16'h3000, 8'h77);
        issue_rd(16'h2000, 8'h3C);
        tick();
        tick();
        chk("pri_rd_first", 32'(s_mem_rd), 1);
        chk("pri_no_wr", 32'(s_mem_wr), 0);
        chk("pri_rd_addr", 32'(mem_addr_o), 32'h2000);
        got_wr = 0;
        for (int i = 0; i < 20 && !got_wr; i++) begin
            tick();
            got_wr = s_mem_wr;
        end
        chk("pri_wr_after", 32'(got_wr), 1);
        chk("pri_wr_addr", 32'(mem_addr_o), 32'h3000);
        chk("pri_wr_data", 32'(mem_wdata_o), 32'h77);
        chk("pri_rd_replied", 32'(exp_q.size()), 0);
        wait_idle("pri_done");
        chk("pri_mem_written", 32'(mem[16'h3000]), 32'h77);

        // Timeout
        do_reset();
        ack_delay = -1;
        issue_rd(16'h4444, 8'h80);
        hi_cnt = 0;
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) begin
            tick();
            if (s_mem_rd) hi_cnt++;
        end
        chk("tmo_rd_cycles", 32'(hi_cnt), 32);
        chk("tmo_replied", 32'(exp_q.size()), 0);
        ack_delay = 1;
        issue_rd(16'h4444, 8'h29);
        tick();
        chk("tmo_no_cache", 32'(s_ready), 0);
        tick();
        chk("tmo_refetch", 32'(s_mem_rd), 1);
        wait_idle("tmo_done");

        // Overruns
        do_reset();
        ack_delay = 5;
        issue_rd(16'h5000, mem[16'h5000]);
        tick();
        tick();
        chk("ovr_in_rdmem", 32'(s_mem_rd), 1);
        wave_rd_i = 1;
        wave_address_i = 16'h5001;
        issue_wr(16'h6000, 8'hAA);
        tick();
        issue_wr(16'h6000, 8'hBB);
        tick();
        chk("ovr_flag", 32'(overrun_o), 1);
        wait_idle("ovr_done");
        repeat (5) tick();
        chk("ovr_sticky", 32'(overrun_o), 1);
        chk("ovr_first_write", 32'(mem[16'h6000]), 32'hAA);

        // Reset during RD_MEM
        do_reset();
        ack_delay = 1;
        issue_rd(16'h7000, mem[16'h7000]);
        wait_idle("rstm_fill");
        issue_rd(16'h7000, mem[16'h7000]);
        tick();
        chk("rstm_hit_before", 32'(s_ready), 1);
        ack_delay = -1;
        issue_rd(16'h7100, mem[16'h7100]);
        tick();
        tick();
        chk("rstm_in_rdmem", 32'(s_mem_rd), 1);
        #2 reset_n_i = 0;
        #1;
        chk("rstm_async_rd", 32'(mem_rd_o), 0);
        chk("rstm_async_addr", 32'(mem_addr_o), 0);
        chk("rstm_async_rdy", 32'(wave_data_ready_o), 0);
        chk("rstm_async_data", 32'(wave_data_o), 0);
        do_reset();
        ack_delay = 1;
        issue_rd(16'h7000, mem[16'h7000]);
        tick();
        chk("rstm_cache_miss", 32'(s_ready), 0);
        tick();
        chk("rstm_refetch", 32'(s_mem_rd), 1);
        wait_idle("rstm_done");

        // Randomized traffic on a small address pool
        do_reset();
        ack_delay = -2;
        for (int i = 0; i < 8; i++) shadow[i] = mem[16'hA000 + 16'(i)];
        for (int c = 0; c < 3000; c++) begin
            tick();
            chk("rnd_no_overrun", 32'(overrun_o), 0);
            if (!busy_m && ($urandom_range(0, 3) == 0)) begin
                a = 16'hA000 + 16'($urandom_range(0, 7));
                d = 8'($urandom);
                issue_wr(a, d);
                shadow[a[2:0]] = d;
            end
            if (exp_q.size() == 0 && ($urandom_range(0, 2) == 0)) begin
                a = 16'hA000 + 16'($urandom_range(0, 7));
                issue_rd(a, shadow[a[2:0]]);
            end
        end
        wait_idle("rnd_drain");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
